// File: rtl/logic_op_pkg.sv
// Shared types for the logic-op issuer: FIFO depth default, command entry layout
// and FSM state encoding.
package logic_op_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned ENTRY_W       = 17;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
  } cmd_t;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StDrive = 2'b01,
    StHold  = 2'b10
  } state_e;

endpackage

// File: rtl/logic_op_issuer_if.sv
// Command, selector and result signals of the issuer; slave is the issuer side,
// master is the environment (command source, selector, result consumer).
interface logic_op_issuer_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_s;
  logic [7:0] sel_a;
  logic [7:0] sel_b;
  logic       sel_s;
  logic [7:0] sel_z;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_z;
  logic       res_s;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_s, sel_z, res_ready,
    input  cmd_ready, sel_a, sel_b, sel_s, res_valid, res_z, res_s
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_s, sel_z, res_ready,
    output cmd_ready, sel_a, sel_b, sel_s, res_valid, res_z, res_s
  );

endinterface

// File: rtl/cmd_fifo.sv
// Command FIFO: power-of-two depth, wrapping pointers, occupancy count.
// Push when full and pop when empty are ignored.
module cmd_fifo
  import logic_op_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [ENTRY_W-1:0]     wdata,
  input  logic                   pop,
  output logic [ENTRY_W-1:0]     rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q;
  logic               push_ok, pop_ok;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/logic_op_issuer.sv
// Queues AND/OR commands, drives them one at a time onto an external logic
// selector and returns the captured results in order over a valid/ready port.
module logic_op_issuer
  import logic_op_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  logic_op_issuer_if.slave       bus,
  output logic [$clog2(DEPTH):0] count
);

  state_e     state_q, state_d;
  cmd_t       wr_cmd, head;
  logic       full, empty, push, pop;
  logic [7:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d, res_z_q, res_z_d;
  logic       sel_s_q, sel_s_d, res_s_q, res_s_d, res_valid_q, res_valid_d;

  // Ready depends only on registered occupancy, so a pop cannot free a full slot early.
  assign bus.cmd_ready = ~full & rst_n;
  assign push          = bus.cmd_valid & bus.cmd_ready;
  assign wr_cmd        = '{a: bus.cmd_a, b: bus.cmd_b, s: bus.cmd_s};

  cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_cmd),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_d     = state_q;
    sel_a_d     = sel_a_q;
    sel_b_d     = sel_b_q;
    sel_s_d     = sel_s_q;
    res_z_d     = res_z_q;
    res_s_d     = res_s_q;
    res_valid_d = res_valid_q;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StDrive;
        end
      end
      StDrive: begin
        res_z_d     = bus.sel_z;
        res_s_d     = sel_s_q;
        res_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = StDrive;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Every pop loads the head onto the selector inputs.
    if (pop) begin
      sel_a_d = head.a;
      sel_b_d = head.b;
      sel_s_d = head.s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sel_a_q     <= '0;
      sel_b_q     <= '0;
      sel_s_q     <= 1'b0;
      res_z_q     <= '0;
      res_s_q     <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      sel_s_q     <= sel_s_d;
      res_z_q     <= res_z_d;
      res_s_q     <= res_s_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.sel_a     = sel_a_q;
  assign bus.sel_b     = sel_b_q;
  assign bus.sel_s     = sel_s_q;
  assign bus.res_z     = res_z_q;
  assign bus.res_s     = res_s_q;
  assign bus.res_valid = res_valid_q;

endmodule

// File: tb/tb_logic_op_issuer.sv
// Directed self-checking bench for logic_op_issuer; a behavioural logic selector
// closes the SEL_* / SEL_Z loop.
module tb_logic_op_issuer;

  logic       clk;
  logic       rst_n;
  logic [2:0] count;
  int         n_checks = 0;
  int         n_errors = 0;

  logic_op_issuer_if bus ();

  logic_op_issuer #(
    .DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .count (count)
  );

  // External logic selector: 0 = AND, 1 = OR.
  assign bus.sel_z = bus.sel_s ? (bus.sel_a | bus.sel_b) : (bus.sel_a & bus.sel_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic acc = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_s     = s;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("push_accepted", acc, 1);
  endtask

  // Waits for one presented result, checks it and lets the consuming edge pass.
  task automatic expect_result(input string tag, input logic [7:0] z, input logic s);
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.res_valid) begin
        seen = 1'b1;
        check({tag, "_z"}, bus.res_z, z);
        check({tag, "_s"}, bus.res_s, s);
      end
      tick();
    end
    check({tag, "_seen"}, seen, 1);
  endtask

  logic [7:0] wa [10] = '{8'h12, 8'h12, 8'hFF, 8'h80, 8'h5A, 8'h5A, 8'h3C, 8'h3C, 8'hE7, 8'h01};
  logic [7:0] wb [10] = '{8'h34, 8'h34, 8'h0F, 8'h01, 8'hA5, 8'hA5, 8'h66, 8'h66, 8'h7E, 8'hFE};
  logic       ws [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] wz [10] = '{8'h10, 8'h36, 8'h0F, 8'h81, 8'h00, 8'hFF, 8'h24, 8'h7E, 8'h66, 8'hFF};

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_s     = 1'b0;
    bus.res_ready = 1'b1;

    // Reset state
    #3;
    check("rst_count", count, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_sel_a", bus.sel_a, 0);
    check("rst_res_z", bus.res_z, 0);
    #20;
    rst_n = 1'b1;
    #1;
    check("rel_cmd_ready", bus.cmd_ready, 1);
    tick();

    // Single AND, latency
    push(8'd2, 8'd54, 1'b0);
    check("and_count_e0", count, 1);
    check("and_valid_e0", bus.res_valid, 0);
    tick();
    check("and_sel_a_e1", bus.sel_a, 2);
    check("and_sel_b_e1", bus.sel_b, 54);
    check("and_valid_e1", bus.res_valid, 0);
    tick();
    check("and_valid_e2", bus.res_valid, 1);
    check("and_z_e2", bus.res_z, 2);
    check("and_s_e2", bus.res_s, 0);
    tick();
    check("and_valid_e3", bus.res_valid, 0);
    tick();

    // Back-to-back, one result per two cycles
    push(8'd2, 8'd7, 1'b0);
    push(8'd2, 8'd14, 1'b1);
    tick();
    check("b2b_valid_1", bus.res_valid, 1);
    check("b2b_z_1", bus.res_z, 2);
    check("b2b_s_1", bus.res_s, 0);
    tick();
    check("b2b_gap", bus.res_valid, 0);
    tick();
    check("b2b_valid_2", bus.res_valid, 1);
    check("b2b_z_2", bus.res_z, 14);
    check("b2b_s_2", bus.res_s, 1);
    tick();
    check("b2b_done", bus.res_valid, 0);
    tick();

    // Fill under backpressure
    bus.res_ready = 1'b0;
    push(8'hF0, 8'h3C, 1'b0);
    push(8'hF0, 8'h3C, 1'b1);
    push(8'hAA, 8'h55, 1'b1);
    push(8'hAA, 8'h55, 1'b0);
    push(8'h81, 8'h18, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 8'hFF;
    bus.cmd_b     = 8'hFF;
    bus.cmd_s     = 1'b0;
    tick();
    tick();
    check("fill_count", count, 4);
    check("fill_cmd_ready", bus.cmd_ready, 0);
    check("fill_sel_a_held", bus.sel_a, 8'hF0);
    check("fill_res_z", bus.res_z, 8'h30);
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    expect_result("fill_r0", 8'h30, 1'b0);
    expect_result("fill_r1", 8'hFC, 1'b1);
    expect_result("fill_r2", 8'hFF, 1'b1);
    expect_result("fill_r3", 8'h00, 1'b0);
    expect_result("fill_r4", 8'h99, 1'b1);
    tick();
    check("fill_empty", count, 0);
    check("fill_no_extra", bus.res_valid, 0);

    // Backpressure stability
    bus.res_ready = 1'b0;
    push(8'hC3, 8'h5A, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", bus.res_valid, 1);
      check("bp_z", bus.res_z, 8'hDB);
      check("bp_s", bus.res_s, 1);
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    check("bp_release", bus.res_valid, 0);
    tick();

    // Reset in HOLD with three queued
    bus.res_ready = 1'b0;
    push(8'h11, 8'h22, 1'b1);
    push(8'h33, 8'h44, 1'b1);
    push(8'h55, 8'h66, 1'b1);
    push(8'h77, 8'h88, 1'b1);
    check("mid_count", count, 3);
    check("mid_valid", bus.res_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_ready", bus.cmd_ready, 0);
    check("mid_rst_valid", bus.res_valid, 0);
    check("mid_rst_z", bus.res_z, 0);
    check("mid_rst_s", bus.res_s, 0);
    check("mid_rst_sel", {bus.sel_a, bus.sel_b, 7'd0, bus.sel_s}, 0);
    #2;
    rst_n         = 1'b1;
    bus.res_ready = 1'b1;
    #1;
    check("mid_rel_ready", bus.cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_no_stale", bus.res_valid, 0);
      check("mid_rel_count", count, 0);
    end

    // Wrap-around with concurrent issue and collection
    fork
      begin
        for (int i = 0; i < 10; i++) push(wa[i], wb[i], ws[i]);
      end
      begin
        for (int i = 0; i < 10; i++) expect_result($sformatf("wrap_r%0d", i), wz[i], ws[i]);
      end
    join
    tick();
    check("wrap_empty", count, 0);
    check("wrap_idle", bus.res_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
